// File: rtl/sdram_bus_pkg.sv
// Shared definitions for the 32-bit bus to 16-bit SDRAM controller bridge.
//   state_t        : adapter FSM states
//   SD_CMD_*       : command encodings on the controller command port
//   byte_merge()   : replaces the bytes of an old word selected by be with new data
package sdram_bus_pkg;

  typedef enum logic [2:0] {
    FLUSH,
    IDLE,
    RD_CMD,
    RD_HI,
    WR_CMD,
    WR_WAIT,
    DONE
  } state_t;

  localparam logic [1:0] SD_CMD_IDLE  = 2'd0;
  localparam logic [1:0] SD_CMD_WRITE = 2'd1;
  localparam logic [1:0] SD_CMD_READ  = 2'd2;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sdram_bus_if.sv
// SoC word-bus side of the SDRAM bridge.
//   a     : byte address (bits [1:0] ignored by the slave)
//   d/be  : write data and byte enables
//   we/rd : request levels, held by the master until ready
//   spo   : read data, valid with ready and held until the next read
//   ready : one-cycle completion pulse
//   busy  : slave is not idle
interface sdram_bus_if #(
  parameter int USER_ADDRESS_WIDTH = 24
);
  logic [USER_ADDRESS_WIDTH:0] a;
  logic [31:0]                 d;
  logic [3:0]                  be;
  logic                        we;
  logic                        rd;
  logic [31:0]                 spo;
  logic                        ready;
  logic                        busy;

  modport master (output a, d, be, we, rd, input spo, ready, busy);
  modport slave  (input a, d, be, we, rd, output spo, ready, busy);
endinterface

// File: rtl/sdram_bus_adapter.sv
// Bridges a 32-bit word bus onto the 16-bit port of sdram_controller
// (read burst 2, write burst 1). Each word is one aligned two-beat burst,
// low halfword first. Partial writes are read-modify-write because the
// controller never masks bytes.
// Ports:
//   clk, rst    : clock shared with the controller, sync active-high reset
//   bus         : word-bus slave (a, d, be, we, rd, spo, ready, busy)
//   sd_command  : 0 idle, 1 write, 2 read
//   sd_address  : halfword address of the burst's first beat
//   sd_wdata    : write beat data
//   sd_rdata    : read beat data, qualified by sd_rvalid
//   sd_wdone    : controller write-done level
module sdram_bus_adapter
  import sdram_bus_pkg::*;
#(
  parameter int USER_ADDRESS_WIDTH = 24,
  parameter int FLUSH_CYCLES       = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  sdram_bus_if.slave                    bus,
  output logic [1:0]                    sd_command,
  output logic [USER_ADDRESS_WIDTH-1:0] sd_address,
  output logic [15:0]                   sd_wdata,
  input  logic [15:0]                   sd_rdata,
  input  logic                          sd_rvalid,
  input  logic                          sd_wdone
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);

  state_t             state;
  logic [CNT_W-1:0]   flush_cnt;
  logic [31:0]        spo;
  logic               ready;
  logic               busy;

  // Request and burst data registers; only read in states that wrote them first.
  logic [31:0]        d_lat;
  logic [3:0]         be_lat;
  logic               is_rmw;
  logic [15:0]        rd_lo;
  logic [31:0]        wr_word;
  logic [31:0]        merged;

  assign bus.spo   = spo;
  assign bus.ready = ready;
  assign bus.busy  = busy;

  // Word just read (high beat arriving now) overlaid with the pending write bytes.
  assign merged = byte_merge({sd_rdata, rd_lo}, d_lat, be_lat);

  always_ff @(posedge clk) begin
    if (rst) begin
      // The controller has no reset and may still be mid-burst; FLUSH waits it out.
      state      <= FLUSH;
      flush_cnt  <= '0;
      spo        <= '0;
      ready      <= 1'b0;
      busy       <= 1'b1;
      sd_command <= SD_CMD_IDLE;
      sd_address <= '0;
      sd_wdata   <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        FLUSH: begin
          busy <= 1'b1;
          if (flush_cnt == FLUSH_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end

        IDLE: begin
          if (bus.rd || bus.we) begin
            d_lat      <= bus.d;
            be_lat     <= bus.be;
            sd_address <= {bus.a[USER_ADDRESS_WIDTH:2], 1'b0};
            busy       <= 1'b1;
            if (bus.rd) begin
              is_rmw     <= 1'b0;
              sd_command <= SD_CMD_READ;
              state      <= RD_CMD;
            end else if (bus.be == 4'hF) begin
              wr_word    <= bus.d;
              sd_wdata   <= bus.d[15:0];
              sd_command <= SD_CMD_WRITE;
              state      <= WR_CMD;
            end else if (bus.be == 4'h0) begin
              // Nothing to write: complete without touching SDRAM.
              ready <= 1'b1;
              state <= DONE;
            end else begin
              is_rmw     <= 1'b1;
              sd_command <= SD_CMD_READ;
              state      <= RD_CMD;
            end
          end
        end

        RD_CMD: begin
          if (sd_rvalid) begin
            rd_lo      <= sd_rdata;
            sd_command <= SD_CMD_IDLE;
            state      <= RD_HI;
          end
        end

        RD_HI: begin
          if (sd_rvalid) begin
            if (is_rmw) begin
              wr_word    <= merged;
              sd_wdata   <= merged[15:0];
              sd_command <= SD_CMD_WRITE;
              state      <= WR_CMD;
            end else begin
              spo   <= {sd_rdata, rd_lo};
              ready <= 1'b1;
              state <= DONE;
            end
          end
        end

        WR_CMD: begin
          // The controller takes the low beat in the cycle it raises wdone.
          if (sd_wdone) begin
            sd_wdata   <= wr_word[31:16];
            sd_command <= SD_CMD_IDLE;
            state      <= WR_WAIT;
          end
        end

        WR_WAIT: begin
          if (!sd_wdone) begin
            ready <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          // Master still holds rd/we this cycle; give it time to drop them.
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= FLUSH;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/sdram_bus_adapter.md
Name: sdram_bus_adapter

Overview:
- Bridges the SoC's 32-bit word bus (a/d/we/rd/spo/ready) to the 16-bit command/data port of sdram_controller, which runs with READ_BURST_LENGTH=2 and WRITE_BURST=1.
- Each bus word maps to one aligned 2-beat SDRAM burst: low halfword first, then high halfword.
- Partial-byte writes are done as read-modify-write, because the controller holds dqm at 0.
- Sits directly upstream of sdram_controller, in the same clock domain.

Parameters:
- USER_ADDRESS_WIDTH, 24: controller halfword address width (bank+row+column).
- FLUSH_CYCLES, 32: cycles with command held at idle after reset before any request is accepted; must exceed the longest controller operation.

Ports:
- clk, input, 1: system clock, shared with sdram_controller.
- rst, input, 1: synchronous, active-high reset.
- a, input, USER_ADDRESS_WIDTH+1: bus byte address; bits [1:0] are ignored.
- d, input, 32: bus write data.
- be, input, 4: byte enables for writes; be[0] selects d[7:0].
- we, input, 1: write request level, held until ready.
- rd, input, 1: read request level, held until ready.
- spo, output, 32: read data, valid with ready and held until the next read completes.
- ready, output, 1: one-cycle completion pulse.
- busy, output, 1: high in every state except IDLE.
- sd_command, output, 2: to controller command (0 idle, 1 write, 2 read).
- sd_address, output, USER_ADDRESS_WIDTH: to controller data_address.
- sd_wdata, output, 16: to controller data_write.
- sd_rdata, input, 16: from controller data_read.
- sd_rvalid, input, 1: from controller data_read_valid.
- sd_wdone, input, 1: from controller data_write_done.

Behaviour:
- Reset values: spo=0, ready=0, busy=1, sd_command=0, sd_address=0, sd_wdata=0. State becomes FLUSH with counter=0.
- Reset mid-operation: the controller has no reset and finishes its in-flight op on its own. The adapter drops sd_command immediately and sits in FLUSH, ignoring sd_rvalid/sd_wdone.
- FLUSH: counts to FLUSH_CYCLES-1, then goes to IDLE.
- IDLE: busy=0.
  - rd has priority when rd and we are both high.
  - On acceptance, latch a, d and be; sd_address={a[USER_ADDRESS_WIDTH:2],1'b0}.
  - rd, or we with be≠4'hF, goes to RD_CMD. we with be=4'hF goes to WR_CMD.
  - we with be=0 completes at once: ready=1 in the next cycle, no SDRAM access.
- RD_CMD: sd_command=2 held until the first cycle sd_rvalid=1.
  - In that cycle capture sd_rdata into the low half, drop sd_command to 0 the next cycle, and go to RD_HI.
- RD_HI: the next cycle with sd_rvalid=1 captures the high half.
  - If the access is a pure read: spo gets the word, ready pulses next cycle, go to DONE.
  - If it is an RMW: merge latched d into the read word per be (be bit=1 takes d), store the result as the write word, go to WR_CMD.
  - sd_rvalid=0 between the beats is tolerated; the state waits.
- WR_CMD: sd_command=1 and sd_wdata=low half of the write word.
  - On the first cycle sd_wdone=1, drive sd_wdata=high half from the next cycle, drop sd_command to 0, and go to WR_WAIT.
- WR_WAIT: hold sd_wdata=high half until sd_wdone falls, then pulse ready and go to DONE.
- DONE: one cycle with requests ignored; the master drops rd/we the cycle after ready. Then return to IDLE.
- Any sd_rvalid or sd_wdone seen in IDLE, FLUSH or DONE is ignored.
- Latency is fully controller-dependent. No timeout.
- Address arithmetic is unsigned; there is no wrap handling because the bus width equals controller space.

Decomposition:
- Package sdram_bus_pkg holds:
  - the state enum (FLUSH, IDLE, RD_CMD, RD_HI, WR_CMD, WR_WAIT, DONE);
  - the SD_CMD_IDLE/SD_CMD_WRITE/SD_CMD_READ constants, also used by sdram_controller wrappers;
  - a byte-merge function (old word, new word, be) returning the merged word.
- No sub-module; a single FSM with one datapath register set.
- The bench model of the controller lives in the testbench only.

Test Plan:
- Reset, then rd at a=0x000010 → no sd_command during 32 FLUSH cycles; then sd_command=2 with sd_address=0x000008. Model returns 0xBEEF, 0xDEAD → spo=0xDEADBEEF, one ready pulse.
- we, be=F, a=0x20, d=0x12345678 → sd_command=1, sd_address=0x10. The model captures 0x5678 then 0x1234; ready pulses once; no read is issued.
- we, be=4'b0100, d=0x00AB0000 over stored 0x11223344 → read burst then write burst. The model stores 0x11AB3344.
- we, be=0 → ready on the next cycle, sd_command stays 0.
- rd and we asserted together → only the read is performed, a single ready pulse. The master holding rd through DONE produces no second access.
- Assert rst during RD_HI, with the model still emitting the second sd_rvalid → the beat is ignored, spo=0, ready never pulses. A fresh read after FLUSH returns correct data.
